// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: FSM state, latched request, helpers.
// Optional parity column is enabled with DATA_MEM_RESPONDER_PARITY_EN.
package data_mem_responder_pkg;

    localparam int BYTE_OFFSET_BITS = 2;
    localparam int REQ_ADDR_W       = 32;
    localparam int REQ_DATA_W       = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    typedef struct packed {
        logic                    write;
        logic [REQ_ADDR_W-1:0]   addr;
        logic [REQ_DATA_W-1:0]   wdata;
        logic [REQ_DATA_W/8-1:0] be;
    } mem_req_t;

    function automatic logic even_parity(input logic [REQ_DATA_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store port (master) and the responder (slave).
// Ports: req_valid/req_ready/req_write/req_addr/req_wdata/req_be, resp_valid/resp_ready/resp_rdata/resp_err.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder_mem_resp_array.sv
// Word storage with per-byte write enables and a registered read port.
// Ports: clk, rst (async low), access strobe, wr_en/rd_en, idx, wdata, be -> rd_data, par_err.
// DATA_MEM_RESPONDER_PARITY_EN adds one even-parity bit per word checked on reads.
module mem_resp_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    access,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    par_err
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] merged;

    assign cur = mem[idx];

    // Full post-write word; parity is taken over this, not the raw wdata.
    always_comb begin
        merged = cur;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (access && wr_en) mem[idx] <= merged;
    end

    // Non-load accesses clear the read register so stores/errors return 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else if (access) rd_data <= rd_en ? cur : '0;
    end

`ifdef DATA_MEM_RESPONDER_PARITY_EN
    logic par [DEPTH];
    logic par_q;

    always_ff @(posedge clk) begin
        if (access && wr_en) par[idx] <= even_parity(merged);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_q <= 1'b0;
        else if (access) par_q <= rd_en && (even_parity(cur) != par[idx]);
    end

    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES latency, held response.
// Ports: clk, rst (async low), bus (slave side). Parity: DATA_MEM_RESPONDER_PARITY_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_SIZE   = 1024,
    parameter int ADDR_WIDTH  = REQ_ADDR_W,
    parameter int DATA_WIDTH  = REQ_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    data_mem_responder_if.slave bus
);
    localparam int IW = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

    resp_state_t state, nxt;
    logic [CW-1:0] cnt;
    mem_req_t req_q, cur;
    logic commit;
    logic accept;
    logic addr_err;
    logic err_q;
    logic par_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-1:0] rd_data;

    assign accept = (state == IDLE) && bus.req_valid;

    // With zero wait the access commits on the accept edge, before req_q is loaded.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur.write = bus.req_write;
            cur.addr  = bus.req_addr;
            cur.wdata = bus.req_wdata;
            cur.be    = bus.req_be;
        end
    end

    // Full-width compare: high index bits must not alias into storage.
    assign word_idx = cur.addr >> BYTE_OFFSET_BITS;
    assign addr_err = (|cur.addr[BYTE_OFFSET_BITS-1:0])
                   || (word_idx >= ADDR_WIDTH'(ADDR_SIZE));

    always_comb begin
        nxt    = state;
        commit = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    nxt    = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    commit = (WAIT_CYCLES == 0);
                end
            end
            WAIT: begin
                if (cnt == LAST) begin
                    nxt    = RESP;
                    commit = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= cur;
                cnt   <= CW'(1);
            end else if (state == WAIT && cnt != LAST) begin
                cnt <= cnt + CW'(1);
            end
            if (commit) err_q <= addr_err;
        end
    end

    mem_resp_array #(
        .DEPTH      (ADDR_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .access  (commit),
        .wr_en   (cur.write && !addr_err),
        .rd_en   (!cur.write && !addr_err),
        .idx     (word_idx[IW-1:0]),
        .wdata   (cur.wdata),
        .be      (cur.be),
        .rd_data (rd_data),
        .par_err (par_err)
    );

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rd_data;
    assign bus.resp_err   = (state == RESP) && (err_q || par_err);

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: spec-level model, per-cycle compare, directed + random.
// Ports exercised: clk, rst, request/response bus (two instances, WAIT_CYCLES=2 and 0).
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int WC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.WAIT_CYCLES(WC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Behavioural model state
    logic [31:0] mmem [int];
    bit          busy = 0;
    bit          committed = 0;
    int          due = 0;
    bit          p_w;
    logic [31:0] p_a, p_d;
    logic [3:0]  p_be;
    logic [31:0] exp_rd = 0;
    bit          exp_err = 0;
    bit          exp_known = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge rst) begin
        busy = 0;
        committed = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                if (cyc >= due && bus.resp_ready) busy = 0;
            end else if (bus.req_valid) begin
                busy = 1;
                committed = 0;
                due = cyc + 1 + WC;
                p_w = bus.req_write;
                p_a = bus.req_addr;
                p_d = bus.req_wdata;
                p_be = bus.req_be;
            end
            if (busy && !committed && cyc == due - 1) begin
                int idx;
                committed = 1;
                idx = int'(p_a >> 2);
                exp_err = (p_a[1:0] != 2'b00) || ((p_a >> 2) >= 32'd1024);
                exp_rd = 32'h0;
                exp_known = 1;
                if (!exp_err) begin
                    if (p_w) begin
                        logic [31:0] w;
                        w = mmem.exists(idx) ? mmem[idx] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (p_be[b]) w[b*8 +: 8] = p_d[b*8 +: 8];
                        mmem[idx] = w;
                    end else begin
                        exp_known = mmem.exists(idx);
                        exp_rd = exp_known ? mmem[idx] : 32'h0;
                    end
                end
            end
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            bit ev;
            ev = busy && (cyc >= due);
            check("req_ready", {31'h0, bus.req_ready}, {31'h0, !busy});
            check("resp_valid", {31'h0, bus.resp_valid}, {31'h0, ev});
            if (ev) begin
                if (exp_known) check("resp_rdata", bus.resp_rdata, exp_rd);
                check("resp_err", {31'h0, bus.resp_err}, {31'h0, exp_err});
            end
        end
    end

    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output bit er, output int lat);
        int n;
        int acc;
        @(negedge clk);
        bus.req_valid = 1;
        bus.req_write = w;
        bus.req_addr = a;
        bus.req_wdata = d;
        bus.req_be = be;
        bus.resp_ready = 0;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'h0, 32'h1);
        acc = cyc;
        @(negedge clk);
        bus.req_valid = 0;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("resp_timeout", 32'h0, 32'h1);
        lat = cyc - acc;
        rd = bus.resp_rdata;
        er = bus.resp_err;
        repeat (hold) @(negedge clk);
        bus.resp_ready = 1;
        @(negedge clk);
        bus.resp_ready = 0;
    endtask

    initial begin
        logic [31:0] rd;
        bit er;
        int lat;
        int acc;
        bus.req_valid = 0;
        bus.req_write = 0;
        bus.req_addr = 0;
        bus.req_wdata = 0;
        bus.req_be = 0;
        bus.resp_ready = 0;
        bus0.req_valid = 0;
        bus0.req_write = 0;
        bus0.req_addr = 0;
        bus0.req_wdata = 0;
        bus0.req_be = 0;
        bus0.resp_ready = 0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        #2 rst = 1;

        for (int i = 0; i < 16; i++)
            xact(1, 32'(i) << 2, $urandom, 4'hF, 0, rd, er, lat);

        xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        check("store_latency", 32'(lat), 32'd3);
        check("store_err", {31'h0, er}, 32'h0);
        check("store_rdata", rd, 32'h0);
        xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("load_latency", 32'(lat), 32'd3);
        check("load_rdata", rd, 32'hDEADBEEF);
        check("load_err", {31'h0, er}, 32'h0);

        xact(1, 32'h10, 32'h12345678, 4'b0011, 0, rd, er, lat);
        xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check("partial_rdata", rd, 32'hDEAD5678);

        xact(1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
        check("be0_err", {31'h0, er}, 32'h0);

        xact(0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat);
        check("misalign_err", {31'h0, er}, 32'h1);
        check("misalign_rdata", rd, 32'h0);
        check("misalign_latency", 32'(lat), 32'd3);
        xact(0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat);
        check("range_err", {31'h0, er}, 32'h1);
        check("range_rdata", rd, 32'h0);
        xact(1, 32'h1010, 32'h11111111, 4'hF, 0, rd, er, lat);
        check("range_store_err", {31'h0, er}, 32'h1);

        xact(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        check("bp_rdata", rd, 32'hDEAD5678);
        check("bp_held_rdata", bus.resp_rdata, 32'hDEAD5678);

        xact(1, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1;
        bus.req_write = 1;
        bus.req_addr = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_be = 4'hF;
        @(negedge clk);
        bus.req_valid = 0;
        #2 rst = 0;
        #1;
        check("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
        check("midrst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("midrst_resp_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        #2 rst = 1;
        xact(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
        check("abort_rdata", rd, 32'h0);

        for (int i = 0; i < 60; i++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 15)) << 2;
            if (r == 8) a = a | 32'($urandom_range(1, 3));
            if (r == 9) a = 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
            xact(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), rd, er, lat);
        end

        @(negedge clk);
        bus0.req_valid = 1;
        bus0.req_write = 1;
        bus0.req_addr = 32'h40;
        bus0.req_wdata = 32'h0BADF00D;
        bus0.req_be = 4'hF;
        check("wc0_ready", {31'h0, bus0.req_ready}, 32'h1);
        acc = cyc;
        @(negedge clk);
        bus0.req_valid = 0;
        check("wc0_store_valid", {31'h0, bus0.resp_valid}, 32'h1);
        check("wc0_store_lat", 32'(cyc - acc), 32'd1);
        bus0.resp_ready = 1;
        @(negedge clk);
        bus0.resp_ready = 0;
        bus0.req_valid = 1;
        bus0.req_write = 0;
        check("wc0_idle", {31'h0, bus0.req_ready}, 32'h1);
        @(negedge clk);
        bus0.req_valid = 0;
        check("wc0_load_valid", {31'h0, bus0.resp_valid}, 32'h1);
        check("wc0_load_rdata", bus0.resp_rdata, 32'h0BADF00D);
        bus0.resp_ready = 1;
        @(negedge clk);
        bus0.resp_ready = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
